// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : match_sequencer
// Description : Pong match controller: serve/goal freeze timing, scoring and
//               winner detection. Define PAUSE_EN to build the pause feature.
// Revision    : 1.0 - initial release
// ============================================================================
module match_sequencer #(
  parameter int WIN_SCORE             = 7,
  parameter int SCORE_WIDTH           = 4,
  parameter int SERVE_DELAY_IN_CLOCKS = 50_000_000,
  parameter int GOAL_HOLD_IN_CLOCKS   = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_pulse,
  input  logic                   pause_pulse,
  input  logic                   goal_1,
  input  logic                   goal_2,
  output logic                   game_run,
  output logic                   ball_reset,
  output logic [SCORE_WIDTH-1:0] score_1,
  output logic [SCORE_WIDTH-1:0] score_2,
  output logic                   game_over,
  output logic                   winner
);

  localparam int c_MAX_DELAY = (SERVE_DELAY_IN_CLOCKS > GOAL_HOLD_IN_CLOCKS) ?
                               SERVE_DELAY_IN_CLOCKS : GOAL_HOLD_IN_CLOCKS;
  localparam int c_CNT_W     = (c_MAX_DELAY > 1) ? $clog2(c_MAX_DELAY) : 1;

  localparam logic [c_CNT_W-1:0]     c_SERVE_LAST = c_CNT_W'(SERVE_DELAY_IN_CLOCKS - 1);
  localparam logic [c_CNT_W-1:0]     c_HOLD_LAST  = c_CNT_W'(GOAL_HOLD_IN_CLOCKS - 1);
  localparam logic [SCORE_WIDTH-1:0] c_WIN        = SCORE_WIDTH'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_GOAL_HOLD  = 3'd3,
    ST_GAME_OVER  = 3'd4
`ifdef PAUSE_EN
    , ST_PAUSED   = 3'd5
`endif
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [SCORE_WIDTH-1:0] r_score_1, w_score_1_nxt, w_score_1_inc;
  logic [SCORE_WIDTH-1:0] r_score_2, w_score_2_nxt, w_score_2_inc;
  logic                   r_winner, w_winner_nxt;
  logic                   r_game_run, r_ball_reset, r_game_over;
  logic                   w_ball_reset_nxt;

`ifndef PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = pause_pulse;
`endif

  assign w_score_1_inc = r_score_1 + SCORE_WIDTH'(1);
  assign w_score_2_inc = r_score_2 + SCORE_WIDTH'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_score_1_nxt = r_score_1;
    w_score_2_nxt = r_score_2;
    w_winner_nxt  = r_winner;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_pulse) begin
          w_state_nxt   = ST_SERVE_WAIT;
          w_cnt_nxt     = '0;
          w_score_1_nxt = '0;
          w_score_2_nxt = '0;
          w_winner_nxt  = 1'b0;
        end
      end
      ST_SERVE_WAIT: begin
        if (r_cnt == c_SERVE_LAST) begin
          w_state_nxt = ST_PLAY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_PLAY: begin
        // Simultaneous goals cancel out and the point is replayed.
        if (goal_1 && goal_2) begin
          w_state_nxt = ST_GOAL_HOLD;
        end else if (goal_1) begin
          w_score_1_nxt = w_score_1_inc;
          if (w_score_1_inc == c_WIN) begin
            w_state_nxt  = ST_GAME_OVER;
            w_winner_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_GOAL_HOLD;
          end
        end else if (goal_2) begin
          w_score_2_nxt = w_score_2_inc;
          if (w_score_2_inc == c_WIN) begin
            w_state_nxt  = ST_GAME_OVER;
            w_winner_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GOAL_HOLD;
          end
        end
`ifdef PAUSE_EN
        else if (pause_pulse) begin
          w_state_nxt = ST_PAUSED;
        end
`endif
      end
      ST_GOAL_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = ST_SERVE_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
`ifdef PAUSE_EN
      ST_PAUSED: begin
        if (pause_pulse) begin
          w_state_nxt = ST_PLAY;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Every entry into the serve wait re-centres the ball exactly once.
    w_ball_reset_nxt = (w_state_nxt == ST_SERVE_WAIT) && (r_state != ST_SERVE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_score_1    <= '0;
      r_score_2    <= '0;
      r_winner     <= 1'b0;
      r_game_run   <= 1'b0;
      r_ball_reset <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_score_1    <= w_score_1_nxt;
      r_score_2    <= w_score_2_nxt;
      r_winner     <= w_winner_nxt;
      r_game_run   <= (w_state_nxt == ST_PLAY);
      r_ball_reset <= w_ball_reset_nxt;
      r_game_over  <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  assign game_run   = r_game_run;
  assign ball_reset = r_ball_reset;
  assign score_1    = r_score_1;
  assign score_2    = r_score_2;
  assign game_over  = r_game_over;
  assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_sequencer
// Description : Self-checking bench for match_sequencer (vector table, directed
//               corner sequences, random stimulus against a timeline model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_sequencer;

  localparam int WIN   = 3;
  localparam int SW    = 4;
  localparam int SERVE = 4;
  localparam int HOLD  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_pulse = 1'b0, pause_pulse = 1'b0, goal_1 = 1'b0, goal_2 = 1'b0;
  logic          game_run, ball_reset, game_over, winner;
  logic [SW-1:0] score_1, score_2;

  int n_vec = 0;
  int n_err = 0;

  match_sequencer #(
    .WIN_SCORE(WIN), .SCORE_WIDTH(SW),
    .SERVE_DELAY_IN_CLOCKS(SERVE), .GOAL_HOLD_IN_CLOCKS(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .goal_1(goal_1), .goal_2(goal_2), .game_run(game_run), .ball_reset(ball_reset),
    .score_1(score_1), .score_2(score_2), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Timeline model: a match is idle, frozen for a number of cycles, playing,
  // over, or paused. A goal freezes for HOLD+SERVE cycles, and the ball is
  // re-centred at the point where only SERVE cycles of freeze remain.
  localparam int M_IDLE = 0, M_FROZEN = 1, M_PLAY = 2, M_OVER = 3, M_PAUSED = 4;
  int m_mode, m_left, m_s1, m_s2, m_win, m_br;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_br = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit g1, input bit g2);
    m_br = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (st) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_mode = M_FROZEN; m_left = SERVE; m_br = 1;
      end
      M_FROZEN: begin
        m_left--;
        if (m_left == SERVE) m_br = 1;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (g1 && g2) begin
          m_mode = M_FROZEN; m_left = HOLD + SERVE;
        end else if (g1 || g2) begin
          if (g1) m_s1++; else m_s2++;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_mode = M_OVER; m_win = g2 ? 1 : 0;
          end else begin
            m_mode = M_FROZEN; m_left = HOLD + SERVE;
          end
        end
`ifdef PAUSE_EN
        else if (pa) m_mode = M_PAUSED;
`endif
      end
      M_PAUSED: if (pa) m_mode = M_PLAY;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("game_run", int'(game_run), (m_mode == M_PLAY) ? 1 : 0);
    check("ball_reset", int'(ball_reset), m_br);
    check("score_1", int'(score_1), m_s1);
    check("score_2", int'(score_2), m_s2);
    check("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    if (m_mode == M_OVER) check("winner", int'(winner), m_win);
  endtask

  // Called #1 after an active edge: drives inputs for one cycle, then compares.
  task automatic cycle(input bit st, input bit pa, input bit g1, input bit g2);
    start_pulse = st; pause_pulse = pa; goal_1 = g1; goal_2 = g2;
    model_step(st, pa, g1, g2);
    @(posedge clk); #1;
    start_pulse = 0; pause_pulse = 0; goal_1 = 0; goal_2 = 0;
    check_model();
  endtask

  task automatic wait_run();
    int k = 0;
    while (!game_run && k < 20) begin
      cycle(0, 0, 0, 0);
      k++;
    end
    if (!game_run) check("wait_run_timeout", 0, 1);
  endtask

  typedef struct {
    bit st, pa, g1, g2;
    bit run, br;
    int s1, s2;
    bit over;
  } vec_t;
  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1,0,0,0, 0,1, 0,0, 0};
    tbl[1]  = '{0,0,0,0, 0,0, 0,0, 0};
    tbl[2]  = '{0,0,0,0, 0,0, 0,0, 0};
    tbl[3]  = '{0,0,0,0, 0,0, 0,0, 0};
    tbl[4]  = '{0,0,0,0, 1,0, 0,0, 0};
    tbl[5]  = '{0,0,0,1, 0,0, 0,1, 0};
    tbl[6]  = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[7]  = '{0,0,0,0, 0,1, 0,1, 0};
    tbl[8]  = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[9]  = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[10] = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[11] = '{0,0,0,0, 1,0, 0,1, 0};
    tbl[12] = '{0,0,1,1, 0,0, 0,1, 0};
    tbl[13] = '{0,0,0,1, 0,0, 0,1, 0};
    tbl[14] = '{0,0,0,0, 0,1, 0,1, 0};
    tbl[15] = '{0,0,1,0, 0,0, 0,1, 0};
    tbl[16] = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[17] = '{0,0,0,0, 0,0, 0,1, 0};
    tbl[18] = '{0,0,0,0, 1,0, 0,1, 0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("reset_run", int'(game_run), 0);
    check("reset_br", int'(ball_reset), 0);
    check("reset_s1", int'(score_1), 0);
    check("reset_s2", int'(score_2), 0);
    check("reset_over", int'(game_over), 0);
    check("reset_winner", int'(winner), 0);

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].st, tbl[i].pa, tbl[i].g1, tbl[i].g2);
      check($sformatf("tbl%0d_run", i), int'(game_run), int'(tbl[i].run));
      check($sformatf("tbl%0d_br", i), int'(ball_reset), int'(tbl[i].br));
      check($sformatf("tbl%0d_s1", i), int'(score_1), tbl[i].s1);
      check($sformatf("tbl%0d_s2", i), int'(score_2), tbl[i].s2);
      check($sformatf("tbl%0d_over", i), int'(game_over), int'(tbl[i].over));
    end

    // Player 1 wins with three goals, each scored from PLAY.
    for (int g = 0; g < 3; g++) begin
      wait_run();
      cycle(0, 0, 1, 0);
    end
    check("win_s1", int'(score_1), 3);
    check("win_over", int'(game_over), 1);
    check("win_winner", int'(winner), 0);
    check("win_run", int'(game_run), 0);
    cycle(0, 0, 0, 1);
    check("over_goal2_s2", int'(score_2), 1);
    cycle(1, 0, 0, 0);
    check("restart_s1", int'(score_1), 0);
    check("restart_over", int'(game_over), 0);
    check("restart_br", int'(ball_reset), 1);

    // Asynchronous reset while in PLAY with score_1 = 2.
    wait_run(); cycle(0, 0, 1, 0);
    wait_run(); cycle(0, 0, 1, 0);
    wait_run();
    check("pre_reset_s1", int'(score_1), 2);
    @(negedge clk); rst = 1; #1;
    model_reset();
    check("async_run", int'(game_run), 0);
    check("async_s1", int'(score_1), 0);
    check("async_br", int'(ball_reset), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    cycle(0, 0, 1, 0);
    check("idle_goal_s1", int'(score_1), 0);
    cycle(1, 0, 0, 0);
    wait_run();

    // Pause toggle (only takes effect when the feature is built).
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    check("after_pause_br", int'(ball_reset), 0);
    cycle(0, 1, 1, 0);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(15) == 0, $urandom_range(7) == 0,
            $urandom_range(7) == 0, $urandom_range(7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
